// File: rtl/cla_carry_increment_adder.sv
// Registered N-bit carry-increment adder with growing group widths: {cout,sum} = a + b + cin.
// Optional macro CIA_INPUT_REG_EN adds an input register stage (latency 2 instead of 1).
module cla_carry_increment_adder #(
    parameter int N           = 32,
    parameter int FIRST_GROUP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         out_valid
);

    // Group g starts at g*FIRST_GROUP + g*(g-1)/2 and is FIRST_GROUP+g wide.
    function automatic int grp_lo(input int g);
        return g * FIRST_GROUP + (g * (g - 1)) / 2;
    endfunction

    function automatic int grp_w(input int g);
        int lo;
        int w;
        lo = grp_lo(g);
        w  = FIRST_GROUP + g;
        if (lo + w > N) begin
            w = N - lo;
        end
        return w;
    endfunction

    function automatic int num_groups();
        int n;
        n = 0;
        for (int g = 0; g <= N; g++) begin
            if (grp_lo(g) < N) begin
                n = g + 1;
            end
        end
        return n;
    endfunction

    localparam int NUM_GROUPS = num_groups();

    // Operands feeding the combinational core.
    logic [N-1:0] core_a;
    logic [N-1:0] core_b;
    logic         core_cin;
    logic         core_valid;

`ifdef CIA_INPUT_REG_EN
    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;
    logic         cin_reg;
    logic         valid_reg;

    // Operands only load with in_valid so idle (possibly X) inputs never enter the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            cin_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                a_reg   <= a;
                b_reg   <= b;
                cin_reg <= cin;
            end
        end
    end

    assign core_a     = a_reg;
    assign core_b     = b_reg;
    assign core_cin   = cin_reg;
    assign core_valid = valid_reg;
`else
    assign core_a     = a;
    assign core_b     = b;
    assign core_cin   = cin;
    assign core_valid = in_valid;
`endif

    logic [NUM_GROUPS-1:0] grp_c0;
    logic [NUM_GROUPS-1:0] grp_p;
    logic [NUM_GROUPS:0]   grp_cin;
    logic [N-1:0]          sum_next;
    logic                  cout_next;

    // Stage 1: each group ripples with carry-in 0 and reports its propagate.
    // Stage 2: the inter-group carry chain selects c0 | (P & carry-in).
    // Stage 3: each group's s0 is incremented by its resolved carry-in.
    generate
        for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_grp
            localparam int LO = grp_lo(gi);
            localparam int W  = grp_w(gi);

            logic [W-1:0] s0;
            logic [W-1:0] gsum;
            logic         c0;
            logic         p;

            always_comb begin
                logic rc;
                logic x;
                rc = 1'b0;
                x  = 1'b0;
                p  = 1'b1;
                s0 = '0;
                for (int i = 0; i < W; i++) begin
                    x     = core_a[LO+i] ^ core_b[LO+i];
                    s0[i] = x ^ rc;
                    rc    = (core_a[LO+i] & core_b[LO+i]) | (x & rc);
                    p     = p & x;
                end
                c0 = rc;
            end

            assign grp_c0[gi] = c0;
            assign grp_p[gi]  = p;

            always_comb begin
                logic ic;
                ic   = grp_cin[gi];
                gsum = '0;
                for (int i = 0; i < W; i++) begin
                    gsum[i] = s0[i] ^ ic;
                    ic      = s0[i] & ic;
                end
            end

            assign sum_next[LO+W-1:LO] = gsum;
        end
    endgenerate

    always_comb begin
        grp_cin    = '0;
        grp_cin[0] = core_cin;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            grp_cin[g+1] = grp_c0[g] | (grp_p[g] & grp_cin[g]);
        end
    end

    assign cout_next = grp_cin[NUM_GROUPS];

    logic [N-1:0] sum_reg;
    logic         cout_reg;
    logic         out_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= core_valid;
            if (core_valid) begin
                sum_reg  <= sum_next;
                cout_reg <= cout_next;
            end
        end
    end

    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_cla_carry_increment_adder.sv
// Directed self-checking bench for cla_carry_increment_adder (N=32, FIRST_GROUP=1).
module tb_cla_carry_increment_adder;

    localparam int N = 32;
`ifdef CIA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;
    logic         out_valid;

    int n_checks;
    int n_fails;

    cla_carry_increment_adder #(.N(N), .FIRST_GROUP(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one operand set, let it through the pipeline, compare sum/cout/out_valid.
    task automatic vec(input string tag, input logic [N-1:0] va, input logic [N-1:0] vb,
                       input logic vc, input logic [N-1:0] esum, input logic ecout);
        @(negedge clk);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        $display("vec %s: a=%08h b=%08h cin=%0d -> sum=%08h cout=%0d", tag, va, vb, vc, sum, cout);
        check({tag, ".sum"}, 64'(sum), 64'(esum));
        check({tag, ".cout"}, 64'(cout), 64'(ecout));
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
    endtask

    // Back-to-back stream, hand-computed expectations.
    logic [N-1:0] s_a    [4] = '{32'h00000001, 32'h7FFFFFFF, 32'hAAAAAAAA, 32'h12345678};
    logic [N-1:0] s_b    [4] = '{32'h00000002, 32'h00000001, 32'h55555555, 32'h11111111};
    logic         s_c    [4] = '{1'b0,         1'b0,         1'b1,         1'b1};
    logic [N-1:0] s_sum  [4] = '{32'h00000003, 32'h80000000, 32'h00000000, 32'h2345678A};
    logic         s_cout [4] = '{1'b0,         1'b0,         1'b1,         1'b0};

    initial begin
        logic [N-1:0] held_sum;
        logic         held_cout;
        logic [N:0]   ref_val;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rc;
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a = '0; b = '0; cin = 1'b0;

        #2;
        check("reset.sum", 64'(sum), 64'd0);
        check("reset.cout", 64'(cout), 64'd0);
        check("reset.valid", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        vec("spec1", 32'h00003A9A, 32'h0000E544, 1'b1, 32'h00011FDF, 1'b0);
        vec("spec2", 32'd521,      32'd856,      1'b1, 32'd1378,     1'b0);
        vec("spec3", 32'hD47856ED, 32'hDCBE1597, 1'b1, 32'hB1366C85, 1'b1);
        vec("zero",  32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0);
        vec("maxall",32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1);
        vec("msb",   32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1);
        vec("grpx",  32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0);
        vec("cin_only", 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0);
        vec("chain", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1);

        // Idle cycles with new operands and then X operands: outputs must hold.
        held_sum  = 32'h00000000;
        held_cout = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = 32'h12345678; b = 32'h9ABCDEF0; cin = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        $display("hold: sum=%08h cout=%0d out_valid=%0d", sum, cout, out_valid);
        check("hold.sum", 64'(sum), 64'(held_sum));
        check("hold.cout", 64'(cout), 64'(held_cout));
        check("hold.valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        a = 'x; b = 'x; cin = 1'bx;
        repeat (LAT + 1) @(posedge clk);
        #1;
        $display("xhold: sum=%08h cout=%0d out_valid=%0d", sum, cout, out_valid);
        check("xhold.sum", 64'(sum), 64'(held_sum));
        check("xhold.cout", 64'(cout), 64'(held_cout));
        check("xhold.valid", 64'(out_valid), 64'd0);

        // Back-to-back: after edge k the output reflects the vector driven LAT-1 cycles earlier.
        for (int k = 0; k < 4 + LAT - 1; k++) begin
            @(negedge clk);
            if (k < 4) begin
                a = s_a[k]; b = s_b[k]; cin = s_c[k]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (k >= LAT - 1) begin
                $display("b2b %0d: sum=%08h cout=%0d", k - LAT + 1, sum, cout);
                check($sformatf("b2b%0d.sum", k - LAT + 1), 64'(sum), 64'(s_sum[k-LAT+1]));
                check($sformatf("b2b%0d.cout", k - LAT + 1), 64'(cout), 64'(s_cout[k-LAT+1]));
                check($sformatf("b2b%0d.valid", k - LAT + 1), 64'(out_valid), 64'd1);
            end
        end

        // Random operands against an (N+1)-bit reference.
        for (int i = 0; i < 200; i++) begin
            ra = $urandom();
            rb = $urandom();
            rc = 1'($urandom_range(0, 1));
            ref_val = {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc};
            vec($sformatf("rnd%0d", i), ra, rb, rc, ref_val[N-1:0], ref_val[N]);
        end

        // Mid-run reset: clears outputs before any clock edge, drops the concurrent operand.
        @(negedge clk);
        a = 32'h00000005; b = 32'h00000007; cin = 1'b0; in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        $display("midreset: sum=%08h cout=%0d out_valid=%0d", sum, cout, out_valid);
        check("midreset.sum", 64'(sum), 64'd0);
        check("midreset.cout", 64'(cout), 64'd0);
        check("midreset.valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1;
        $display("postreset: sum=%08h cout=%0d out_valid=%0d", sum, cout, out_valid);
        check("postreset.sum", 64'(sum), 64'd0);
        check("postreset.valid", 64'(out_valid), 64'd0);

        vec("after_reset", 32'h00000005, 32'h00000007, 1'b0, 32'h0000000C, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
